// File: rtl/switch_allocator.sv
// Wormhole switch allocator: each crossbar output is locked to one input from head to tail,
// with per-output round-robin arbitration among inputs that do not already own an output.
module switch_allocator #(
   parameter int NUM_PORTS = 7,
   parameter int SEL_W     = $clog2(NUM_PORTS),
   parameter int PORT_W    = 3
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_PORTS-1:0]                req_valid,
   input  logic [NUM_PORTS-1:0][PORT_W-1:0]    req_port,
   input  logic [NUM_PORTS-1:0]                req_tail,
   input  logic [NUM_PORTS-1:0]                out_ready,
   output logic [NUM_PORTS-1:0]                grant,
   output logic [NUM_PORTS-1:0]                out_valid,
   output logic [NUM_PORTS-1:0][SEL_W-1:0]     out_sel
);

   typedef enum logic {FREE = 1'b0, LOCKED = 1'b1} lock_e;

   lock_e            lock_q  [NUM_PORTS];
   lock_e            lock_d  [NUM_PORTS];
   logic [SEL_W-1:0] owner_q [NUM_PORTS];
   logic [SEL_W-1:0] owner_d [NUM_PORTS];
   logic [SEL_W-1:0] rr_q    [NUM_PORTS];
   logic [SEL_W-1:0] rr_d    [NUM_PORTS];

   // req_match[o][i]: input i wants output o (encodings >= NUM_PORTS never match)
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req_match;
   logic [NUM_PORTS-1:0]                xfer;
   logic [NUM_PORTS-1:0]                owns;

   logic [NUM_PORTS-1:0] cand;
   logic                 found;
   logic [SEL_W-1:0]     win;
   logic [SEL_W-1:0]     idx;
   int                   pos;

   genvar gi, gj;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_out
         for (gj = 0; gj < NUM_PORTS; gj++) begin : g_in
            assign req_match[gi][gj] = req_valid[gj] && (req_port[gj] == PORT_W'(gi));
         end
         assign xfer[gi]      = (lock_q[gi] == LOCKED) && req_match[gi][owner_q[gi]] && out_ready[gi];
         assign out_valid[gi] = xfer[gi];
         assign out_sel[gi]   = (lock_q[gi] == LOCKED) ? owner_q[gi] : '0;
      end
   endgenerate

   always_comb begin
      owns  = '0;
      grant = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         if (lock_q[o] == LOCKED) owns[owner_q[o]] = 1'b1;
         if (xfer[o])             grant[owner_q[o]] = 1'b1;
      end
   end

   always_comb begin
      cand  = '0;
      found = 1'b0;
      win   = '0;
      idx   = '0;
      pos   = 0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         lock_d[o]  = lock_q[o];
         owner_d[o] = owner_q[o];
         rr_d[o]    = rr_q[o];
         cand  = req_match[o] & ~owns;
         found = 1'b0;
         win   = '0;
         // Scan upward from the slot after the last winner, wrapping around
         for (int k = 1; k <= NUM_PORTS; k++) begin
            pos = int'(rr_q[o]) + k;
            if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
            idx = SEL_W'(pos);
            if (!found && cand[idx]) begin
               found = 1'b1;
               win   = idx;
            end
         end
         if (lock_q[o] == LOCKED) begin
            if (xfer[o] && req_tail[owner_q[o]]) lock_d[o] = FREE;
         end else if (found) begin
            lock_d[o]  = LOCKED;
            owner_d[o] = win;
            rr_d[o]    = win;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            lock_q[o]  <= FREE;
            owner_q[o] <= '0;
            rr_q[o]    <= SEL_W'(NUM_PORTS - 1);
         end
      end else begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            lock_q[o]  <= lock_d[o];
            owner_q[o] <= owner_d[o];
            rr_q[o]    <= rr_d[o];
         end
      end
   end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed and randomized bench for switch_allocator against a cycle-level reference model.
module tb_switch_allocator;
   localparam int N = 7;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]      req_valid, req_tail, out_ready, grant, out_valid;
   logic [N-1:0][2:0] req_port;
   logic [N-1:0][2:0] out_sel;

   int errors = 0;
   int checks = 0;

   // reference model state
   bit m_lock [N];
   int m_own  [N];
   int m_rr   [N];
   bit n_lock [N];
   int n_own  [N];
   int n_rr   [N];
   logic [N-1:0]      eg, ev;
   logic [N-1:0][2:0] es;

   int pk_dest [N];
   int pk_left [N];

   switch_allocator dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_port  (req_port),
      .req_tail  (req_tail),
      .out_ready (out_ready),
      .grant     (grant),
      .out_valid (out_valid),
      .out_sel   (out_sel)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int o = 0; o < N; o++) begin
         m_lock[o] = 1'b0;
         m_own[o]  = 0;
         m_rr[o]   = N - 1;
      end
   endtask

   // Expected outputs for this cycle and the state after the next edge
   task automatic eval_cmp();
      bit busy [N];
      int best, bd, d, w;
      #1;
      eg = '0; ev = '0; es = '0;
      for (int i = 0; i < N; i++) busy[i] = 1'b0;
      for (int o = 0; o < N; o++) if (m_lock[o]) busy[m_own[o]] = 1'b1;
      for (int o = 0; o < N; o++) begin
         n_lock[o] = m_lock[o];
         n_own[o]  = m_own[o];
         n_rr[o]   = m_rr[o];
         if (m_lock[o]) begin
            w = m_own[o];
            es[o] = 3'(w);
            if (req_valid[w] && req_port[w] == o && out_ready[o]) begin
               ev[o] = 1'b1;
               eg[w] = 1'b1;
               if (req_tail[w]) n_lock[o] = 1'b0;
            end
         end else begin
            best = -1;
            bd   = 99;
            for (int i = 0; i < N; i++) begin
               if (req_valid[i] && req_port[i] == o && !busy[i]) begin
                  d = (i - m_rr[o] - 1 + 2 * N) % N;
                  if (d < bd) begin
                     bd   = d;
                     best = i;
                  end
               end
            end
            if (best >= 0) begin
               n_lock[o] = 1'b1;
               n_own[o]  = best;
               n_rr[o]   = best;
            end
         end
      end
      chk("grant", 32'(grant), 32'(eg));
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("out_sel", 32'(out_sel), 32'(es));
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      for (int o = 0; o < N; o++) begin
         m_lock[o] = n_lock[o];
         m_own[o]  = n_own[o];
         m_rr[o]   = n_rr[o];
      end
   endtask

   task automatic idle_inputs();
      req_valid = '0;
      req_tail  = '0;
      req_port  = '0;
      out_ready = '1;
   endtask

   task automatic new_packet(input int i);
      pk_dest[i] = $urandom_range(0, 7);
      pk_left[i] = $urandom_range(1, 4);
   endtask

   initial begin
      int rr_exp [8];
      rr_exp = '{0, 1, 0, 16, 0, 64, 0, 1};
      idle_inputs();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // reset state
      eval_cmp();
      chk("reset_grant", 32'(grant), 0);
      chk("reset_sel", 32'(out_sel), 0);
      advance();

      // single-flit packet NORTH -> EAST
      req_valid[1] = 1'b1; req_port[1] = 3'd3; req_tail[1] = 1'b1;
      eval_cmp();
      chk("sf_arb_grant", 32'(grant), 0);
      advance();
      eval_cmp();
      chk("sf_grant", 32'(grant), 32'h02);
      chk("sf_valid", 32'(out_valid), 32'h08);
      chk("sf_sel", 32'(out_sel[3]), 1);
      advance();
      idle_inputs();
      eval_cmp();
      chk("sf_free_sel", 32'(out_sel[3]), 0);
      advance();

      // round-robin on UP among inputs 0, 4, 6
      for (int c = 0; c < 8; c++) begin
         req_valid = 7'b1010001;
         req_tail  = 7'b1010001;
         req_port[0] = 3'd5; req_port[4] = 3'd5; req_port[6] = 3'd5;
         eval_cmp();
         chk("rr_grant", 32'(grant), 32'(rr_exp[c]));
         advance();
      end
      idle_inputs();
      eval_cmp();
      advance();

      // wormhole lock of LOCAL by input 3 while input 5 waits
      req_valid[3] = 1'b1; req_port[3] = 3'd0;
      req_valid[5] = 1'b1; req_port[5] = 3'd0; req_tail[5] = 1'b1;
      eval_cmp();
      chk("wh_arb_grant", 32'(grant), 0);
      advance();
      for (int f = 1; f <= 4; f++) begin
         req_tail[3] = (f == 4);
         eval_cmp();
         chk("wh_grant", 32'(grant), 32'h08);
         chk("wh_sel", 32'(out_sel[0]), 3);
         advance();
      end
      req_valid[3] = 1'b0; req_tail[3] = 1'b0;
      eval_cmp();
      chk("wh_rearb_grant", 32'(grant), 0);
      advance();
      eval_cmp();
      chk("wh_next_grant", 32'(grant), 32'h20);
      chk("wh_next_sel", 32'(out_sel[0]), 5);
      advance();
      idle_inputs();
      eval_cmp();
      advance();

      // backpressure and bubble on DOWN for input 2
      req_valid[2] = 1'b1; req_port[2] = 3'd6;
      eval_cmp();
      chk("bp_arb_grant", 32'(grant), 0);
      advance();
      for (int c = 1; c <= 9; c++) begin
         out_ready[6] = !(c >= 2 && c <= 4);
         req_valid[2] = !(c == 5 || c == 6);
         req_tail[2]  = (c == 9);
         eval_cmp();
         chk("bp_grant", 32'(grant), (c == 1 || c >= 7) ? 32'h04 : 0);
         chk("bp_sel", 32'(out_sel[6]), 2);
         advance();
      end
      idle_inputs();
      eval_cmp();
      chk("bp_free_sel", 32'(out_sel[6]), 0);
      advance();

      // parallel outputs plus an invalid encoding on input 4
      req_valid = 7'b0010111;
      req_tail  = 7'b0010111;
      req_port[0] = 3'd3; req_port[1] = 3'd4; req_port[2] = 3'd5; req_port[4] = 3'd7;
      eval_cmp();
      chk("par_arb_grant", 32'(grant), 0);
      advance();
      eval_cmp();
      chk("par_grant", 32'(grant), 32'h07);
      advance();
      req_valid = 7'b0010000;
      for (int c = 0; c < 3; c++) begin
         eval_cmp();
         chk("inv_grant", 32'(grant), 0);
         advance();
      end
      idle_inputs();
      eval_cmp();
      advance();

      // reset mid-packet: EAST locked to input 2
      req_valid[2] = 1'b1; req_port[2] = 3'd3;
      eval_cmp();
      advance();
      eval_cmp();
      chk("rst_pre_grant", 32'(grant), 32'h04);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_sel", 32'(out_sel), 0);
      model_reset();
      req_valid = 7'b0000101;
      req_tail  = 7'b0000101;
      req_port[0] = 3'd3; req_port[2] = 3'd3;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("rst_hold_grant", 32'(grant), 0);
      end
      rst_n = 1'b1;
      eval_cmp();
      chk("rst_arb_grant", 32'(grant), 0);
      advance();
      eval_cmp();
      chk("rst_first_win", 32'(grant), 32'h01);
      advance();
      idle_inputs();
      eval_cmp();
      advance();

      // randomized traffic with wormhole packets
      for (int i = 0; i < N; i++) new_packet(i);
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            req_valid[i] = ($urandom_range(0, 4) != 0);
            req_port[i]  = 3'(pk_dest[i]);
            req_tail[i]  = (pk_left[i] == 1);
            out_ready[i] = ($urandom_range(0, 6) != 0);
         end
         eval_cmp();
         for (int i = 0; i < N; i++) begin
            if (pk_dest[i] == 7 || eg[i]) pk_left[i]--;
            if (pk_left[i] == 0) new_packet(i);
         end
         advance();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-router wormhole switch allocator. It shares the 7 crossbar output ports among the 7 input ports.
- Each input presents the port_t outport produced by its route computation unit (rcu_single) for the flit at its head.
- The allocator locks an output to one input from head flit to tail flit, using per-output round-robin arbitration.
- Its outputs drive the crossbar select lines and the input-buffer pop strobes.

Parameters:
- NUM_PORTS, 7, number of input/output ports. Index = port_t value: LOCAL=0, NORTH=1, SOUTH=2, EAST=3, WEST=4, UP=5, DOWN=6.
- SEL_W, $clog2(NUM_PORTS), width of an input-index select.

Ports:
- clk  input  1  clock. One clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_PORTS  input i has a flit at its buffer head.
- req_port  input  NUM_PORTS x port_t  requested outport per input. Valid only with req_valid[i].
- req_tail  input  NUM_PORTS  head flit of input i is a tail (a single-flit packet sets tail=1 on its head).
- out_ready  input  NUM_PORTS  output o has downstream credit this cycle.
- grant  output  NUM_PORTS  input i is popped this cycle (flit crosses the crossbar).
- out_valid  output  NUM_PORTS  output o carries a flit this cycle.
- out_sel  output  NUM_PORTS x SEL_W  crossbar select: input index driving output o.

Behaviour:
- Per-output state:
  - lock: FREE or LOCKED.
  - owner: SEL_W bits.
  - rr_ptr: SEL_W bits, index of the last winner.
- Reset (asynchronous assert; release synchronous to clk):
  - all outputs FREE, owner=0, rr_ptr=NUM_PORTS-1.
  - grant=0, out_valid=0, out_sel=0.
  - Reset mid-packet drops every lock; no flit is granted until after release.
- Request mapping:
  - input i requests output o iff req_valid[i] && req_port[i]==o.
  - a req_port encoding >= NUM_PORTS is ignored (never granted).
- FREE, arbitration:
  - candidates are requesting inputs that do not currently own any other output.
  - winner = first candidate scanning (rr_ptr+1) mod NUM_PORTS upward, with wrap-around.
  - at the next edge: LOCKED, owner=winner, rr_ptr=winner.
  - no grant in the arbitration cycle. Head-flit latency is 1 cycle from request to earliest grant.
- LOCKED, transfer:
  - grant[owner] = out_valid[o] = req_valid[owner] && req_port[owner]==o && out_ready[o].
  - out_sel[o] = owner while LOCKED, else 0.
  - grant and out_valid are combinational from registered state and current inputs. They are the only combinational paths.
- Tail release:
  - a granted flit with req_tail[owner]=1 returns the output to FREE at the next edge.
  - that same edge may not lock the output to a new winner; re-arbitration starts in the following cycle.
  - minimum occupancy per packet is 2 cycles (arbitrate, transfer).
- Lock holding:
  - owner req_valid=0 (bubble) or out_ready=0 keeps LOCKED with no grant. The lock has no timeout.
- Invariants:
  - each input owns at most one output at a time.
  - grant is asserted for an input only by its owned output, so grant has no multi-drive.
- Simultaneous events: all outputs arbitrate independently in the same cycle. Different outputs may lock different inputs on the same edge.
- Tail-and-arbitrate: an input whose tail is granted at edge N may win another output in cycle N+1, because ownership is cleared at edge N.

Test Plan:
- Reset: assert rst_n=0 mid-packet with output EAST LOCKED to input 2 → grant=0, out_valid=0, all FREE immediately. After release, input 0 wins the first contention.
- Single-flit packet: input 1 (NORTH) requests EAST with tail=1 and out_ready[3]=1 at cycle 0 → cycle 1: grant[1]=1, out_valid[3]=1, out_sel[3]=1. Cycle 2: EAST FREE.
- Round-robin: inputs 0, 4, 6 each send 1-flit packets to UP (5), requesting continuously → grant order 0,4,6,0, with one grant every 2 cycles.
- Wormhole lock: input 3 sends a 4-flit packet to LOCAL while input 5 also requests LOCAL → 4 consecutive grants to input 3 (out_sel[0]=3), then input 5 is locked the cycle after the tail.
- Backpressure and bubble: during a locked packet, drop out_ready[6]=0 for 3 cycles, then req_valid=0 for 2 cycles → no grants, lock held, and the remaining flits complete in order.
- Parallel outputs: inputs 0→EAST, 1→WEST, 2→UP in the same cycle → all three lock on the same edge and grant=0b0000111 in the next cycle. An invalid req_port=7 on input 4 is never granted.
